// File: rtl/ber_log_controller_pkg.sv
// Shared GPIO command-bus definitions for the BER log controller and the
// configuration register file that decodes the same command word.
package ber_log_controller_pkg;

    localparam int GPIO_LEN      = 32;
    localparam int OPCODE_LEN    = 8;
    localparam int LOG_COUNT_LEN = 2 * GPIO_LEN;

    // Command word fields: opcode [31:24], strobe [23], data [22:0]
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int STB_BIT  = 23;
    localparam int DATA_MSB = 22;

    // Opcode map shared across every block on the bus
    localparam logic [OPCODE_LEN-1:0] OPC_NOP       = 8'h00;
    localparam logic [OPCODE_LEN-1:0] OPC_CFG_WR    = 8'h01;
    localparam logic [OPCODE_LEN-1:0] OPC_CFG_RD    = 8'h02;
    localparam logic [OPCODE_LEN-1:0] OPC_LOG_REQ   = 8'h03;
    localparam logic [OPCODE_LEN-1:0] OPC_LOG_READ  = 8'h04;
    localparam logic [OPCODE_LEN-1:0] OPC_LOG_CLEAR = 8'h05;
    localparam logic [OPCODE_LEN-1:0] OPC_STATUS    = 8'h06;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // STATUS response: {snap_valid, busy, 14'b0, seq}
    function automatic logic [GPIO_LEN-1:0] status_word(input logic        valid,
                                                        input logic        busy,
                                                        input logic [15:0] seq);
        return {valid, busy, 14'd0, seq};
    endfunction

endpackage

// File: rtl/log_snapshot_bank.sv
// Four 64-bit snapshot registers captured together on one edge, with a
// validity flag and the 3-bit word-select read mux.
module log_snapshot_bank
    import ber_log_controller_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     capture_i,
    input  logic                     invalidate_i,
    input  logic [LOG_COUNT_LEN-1:0] err_r_i,
    input  logic [LOG_COUNT_LEN-1:0] err_i_i,
    input  logic [LOG_COUNT_LEN-1:0] bit_r_i,
    input  logic [LOG_COUNT_LEN-1:0] bit_i_i,
    input  logic [2:0]               idx_i,
    output logic                     valid_o,
    output logic [GPIO_LEN-1:0]      rd_data_o
);

    logic [LOG_COUNT_LEN-1:0] err_r_q, err_i_q, bit_r_q, bit_i_q;
    logic                     valid_q;

    // Capture all four counters together so the snapshot is coherent
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r_q <= '0;
            err_i_q <= '0;
            bit_r_q <= '0;
            bit_i_q <= '0;
        end else if (capture_i) begin
            err_r_q <= err_r_i;
            err_i_q <= err_i_i;
            bit_r_q <= bit_r_i;
            bit_i_q <= bit_i_i;
        end
    end

    // Validity flag; invalidation wins if both ever coincide
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
        end
    end

    // Word select; an invalid snapshot always reads as zero
    always_comb begin
        rd_data_o = '0;
        if (valid_q) begin
            case (idx_i)
                3'd0:    rd_data_o = err_r_q[31:0];
                3'd1:    rd_data_o = err_r_q[63:32];
                3'd2:    rd_data_o = err_i_q[31:0];
                3'd3:    rd_data_o = err_i_q[63:32];
                3'd4:    rd_data_o = bit_r_q[31:0];
                3'd5:    rd_data_o = bit_r_q[63:32];
                3'd6:    rd_data_o = bit_i_q[31:0];
                default: rd_data_o = bit_i_q[63:32];
            endcase
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/ber_log_controller.sv
// BER log read-out sequencer: decodes GPIO commands 0x03-0x06, freezes a
// coherent snapshot of the four BER counters and serves it as 32-bit words.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no snapshot pending or held
// WAIT    | request seen, counting settle cycles before capture (busy)
// HOLD    | snapshot captured and valid, served on LOG_READ
module ber_log_controller
    import ber_log_controller_pkg::*;
#(
    parameter int CAPTURE_DELAY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [GPIO_LEN-1:0]      gpio_in_i,
    output logic [GPIO_LEN-1:0]      gpio_out_o,
    input  logic [LOG_COUNT_LEN-1:0] error_count_r_i,
    input  logic [LOG_COUNT_LEN-1:0] error_count_i_i,
    input  logic [LOG_COUNT_LEN-1:0] bit_count_r_i,
    input  logic [LOG_COUNT_LEN-1:0] bit_count_i_i,
    output logic                     log_busy_o
);

    // Down-counter preload: terminal count 0 lands exactly CAPTURE_DELAY
    // edges after the request edge
    localparam logic [3:0] DLY_INIT = 4'(CAPTURE_DELAY - 1);

    logic                  stb_q;
    logic [1:0]            state_q, state_d;
    logic [3:0]            dly_q, dly_d;
    logic [15:0]           seq_q, seq_d;
    logic [GPIO_LEN-1:0]   gpio_out_q, gpio_out_d;

    logic                  cmd_stb;
    logic [OPCODE_LEN-1:0] opcode;
    logic                  is_req, is_read, is_clear, is_status;
    logic                  capture, invalidate;
    logic                  snap_valid;
    logic [GPIO_LEN-1:0]   rd_data;
    logic                  unused_data;

    assign cmd_stb   = gpio_in_i[STB_BIT] & ~stb_q;
    assign opcode    = gpio_in_i[OPC_MSB:OPC_LSB];
    assign is_req    = cmd_stb && (opcode == OPC_LOG_REQ);
    assign is_read   = cmd_stb && (opcode == OPC_LOG_READ);
    assign is_clear  = cmd_stb && (opcode == OPC_LOG_CLEAR);
    assign is_status = cmd_stb && (opcode == OPC_STATUS);

    assign unused_data = ^gpio_in_i[DATA_MSB:3];

    log_snapshot_bank u_bank (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .capture_i    (capture),
        .invalidate_i (invalidate),
        .err_r_i      (error_count_r_i),
        .err_i_i      (error_count_i_i),
        .bit_r_i      (bit_count_r_i),
        .bit_i_i      (bit_count_i_i),
        .idx_i        (gpio_in_i[2:0]),
        .valid_o      (snap_valid),
        .rd_data_o    (rd_data)
    );

    // Sequencer: a fresh request always restarts the settle count, and a
    // clear in WAIT aborts before the capture edge can fire
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        seq_d      = seq_q;
        capture    = 1'b0;
        invalidate = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_req) begin
                    state_d    = ST_WAIT;
                    dly_d      = DLY_INIT;
                    invalidate = 1'b1;
                end else if (is_clear) begin
                    invalidate = 1'b1;
                end
            end
            ST_WAIT: begin
                if (is_req) begin
                    dly_d      = DLY_INIT;
                    invalidate = 1'b1;
                end else if (is_clear) begin
                    state_d    = ST_IDLE;
                    invalidate = 1'b1;
                end else if (dly_q == 4'd0) begin
                    state_d = ST_HOLD;
                    capture = 1'b1;
                    seq_d   = seq_q + 16'd1;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (is_req) begin
                    state_d    = ST_WAIT;
                    dly_d      = DLY_INIT;
                    invalidate = 1'b1;
                end else if (is_clear) begin
                    state_d    = ST_IDLE;
                    invalidate = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                invalidate = 1'b1;
            end
        endcase
    end

    // Response word: only READ and STATUS change it, both from pre-edge state
    always_comb begin
        gpio_out_d = gpio_out_q;
        if (is_read) begin
            gpio_out_d = rd_data;
        end else if (is_status) begin
            gpio_out_d = status_word(snap_valid, state_q == ST_WAIT, seq_q);
        end
    end

    // State, counters and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q      <= 1'b0;
            state_q    <= ST_IDLE;
            dly_q      <= 4'd0;
            seq_q      <= 16'd0;
            gpio_out_q <= '0;
        end else begin
            stb_q      <= gpio_in_i[STB_BIT];
            state_q    <= state_d;
            dly_q      <= dly_d;
            seq_q      <= seq_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    assign gpio_out_o = gpio_out_q;
    assign log_busy_o = (state_q == ST_WAIT);

endmodule
